// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared constants and helpers for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;
  localparam int          DEFAULT_IDX_W     = 28;

  localparam logic GNT_ICACHE = 1'b0;
  localparam logic GNT_DCACHE = 1'b1;

  function automatic logic [63:0] wstrb_to_mask(input logic [7:0] wstrb);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[8*i +: 8] = {8{wstrb[i]}};
    end
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_grant.sv
// ============================================================================
// Module      : mem_arb_grant
// Description : Combinational grant between fetch and data requesters.
//               MEM_ARB_ROUND_ROBIN_EN selects alternation on contention,
//               otherwise the data side always wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic i_icache_valid,
  input  logic i_dcache_valid,
  input  logic i_last_grant,
  output logic o_grant_icache,
  output logic o_grant_dcache
);

  logic w_pick_dcache;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On contention the side that lost the previous grant goes next.
  assign w_pick_dcache = (i_last_grant == GNT_ICACHE);
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
  assign w_pick_dcache       = 1'b1;
`endif

  always_comb begin
    o_grant_dcache = i_dcache_valid & (~i_icache_valid | w_pick_dcache);
    o_grant_icache = i_icache_valid & ~o_grant_dcache;
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port simulation memory between fetch and
//               data command interfaces; one command per cycle, registered
//               responses one cycle after acceptance.
//               Optional macro: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_grant).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          IDX_W     = DEFAULT_IDX_W
) (
  input  logic             clock,
  input  logic             reset_n,

  input  logic             icache_cmd_valid,
  output logic             icache_cmd_ready,
  input  logic [63:0]      icache_cmd_payload_addr,
  output logic             icache_rsp_valid,
  output logic [31:0]      icache_rsp_payload_data,

  input  logic             dcache_cmd_valid,
  output logic             dcache_cmd_ready,
  input  logic [63:0]      dcache_cmd_payload_addr,
  input  logic             dcache_cmd_payload_wen,
  input  logic [63:0]      dcache_cmd_payload_wdata,
  input  logic [7:0]       dcache_cmd_payload_wstrb,
  input  logic [2:0]       dcache_cmd_payload_size,
  output logic             dcache_rsp_valid,
  output logic [63:0]      dcache_rsp_payload_data,

  output logic             mem_en,
  output logic [IDX_W-1:0] mem_idx,
  input  logic [63:0]      mem_rdata,
  output logic [63:0]      mem_wdata,
  output logic [63:0]      mem_wmask,
  output logic             mem_wen
);

  logic        w_gnt_i_raw;
  logic        w_gnt_d_raw;
  logic        w_gnt_i;
  logic        w_gnt_d;
  logic [63:0] w_addr;
  logic [63:0] w_off;
  logic        w_unused;

  logic        r_last_grant;
  logic        r_icache_rsp_valid;
  logic [31:0] r_icache_rsp_data;
  logic        r_dcache_rsp_valid;
  logic [63:0] r_dcache_rsp_data;

  mem_arb_grant u_grant (
    .i_icache_valid (icache_cmd_valid),
    .i_dcache_valid (dcache_cmd_valid),
    .i_last_grant   (r_last_grant),
    .o_grant_icache (w_gnt_i_raw),
    .o_grant_dcache (w_gnt_d_raw)
  );

  // Grants are masked by reset so every command-side output reads 0 in reset.
  always_comb begin
    w_gnt_i = w_gnt_i_raw & reset_n;
    w_gnt_d = w_gnt_d_raw & reset_n;
    w_addr  = w_gnt_d ? dcache_cmd_payload_addr : icache_cmd_payload_addr;
    w_off   = w_addr - BASE_ADDR;

    icache_cmd_ready = w_gnt_i;
    dcache_cmd_ready = w_gnt_d;
    mem_en           = w_gnt_i | w_gnt_d;
    mem_idx          = mem_en ? w_off[IDX_W+2:3] : '0;
    mem_wen          = w_gnt_d & dcache_cmd_payload_wen;
    mem_wdata        = w_gnt_d ? dcache_cmd_payload_wdata : 64'd0;
    mem_wmask        = w_gnt_d ? wstrb_to_mask(dcache_cmd_payload_wstrb) : 64'd0;
  end

  assign w_unused = ^{dcache_cmd_payload_size, w_off[63:IDX_W+3], w_off[1:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant       <= GNT_DCACHE;
      r_icache_rsp_valid <= 1'b0;
      r_icache_rsp_data  <= '0;
      r_dcache_rsp_valid <= 1'b0;
      r_dcache_rsp_data  <= '0;
    end else begin
      r_icache_rsp_valid <= w_gnt_i;
      r_dcache_rsp_valid <= w_gnt_d & ~dcache_cmd_payload_wen;
      if (w_gnt_i) begin
        r_last_grant      <= GNT_ICACHE;
        r_icache_rsp_data <= w_off[2] ? mem_rdata[63:32] : mem_rdata[31:0];
      end
      if (w_gnt_d) begin
        r_last_grant <= GNT_DCACHE;
        if (!dcache_cmd_payload_wen) begin
          r_dcache_rsp_data <= mem_rdata;
        end
      end
    end
  end

  assign icache_rsp_valid        = r_icache_rsp_valid;
  assign icache_rsp_payload_data = r_icache_rsp_data;
  assign dcache_rsp_valid        = r_dcache_rsp_valid;
  assign dcache_rsp_payload_data = r_dcache_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a word-level
//               memory model; honours MEM_ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

  localparam logic [63:0] BASE = 64'h8000_0000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        icache_cmd_valid = 1'b0;
  logic        icache_cmd_ready;
  logic [63:0] icache_cmd_payload_addr = '0;
  logic        icache_rsp_valid;
  logic [31:0] icache_rsp_payload_data;
  logic        dcache_cmd_valid = 1'b0;
  logic        dcache_cmd_ready;
  logic [63:0] dcache_cmd_payload_addr = '0;
  logic        dcache_cmd_payload_wen = 1'b0;
  logic [63:0] dcache_cmd_payload_wdata = '0;
  logic [7:0]  dcache_cmd_payload_wstrb = '0;
  logic [2:0]  dcache_cmd_payload_size = 3'd3;
  logic        dcache_rsp_valid;
  logic [63:0] dcache_rsp_payload_data;
  logic        mem_en;
  logic [27:0] mem_idx;
  logic [63:0] mem_rdata;
  logic [63:0] mem_wdata;
  logic [63:0] mem_wmask;
  logic        mem_wen;

  mem_port_arbiter #(.BASE_ADDR(BASE), .IDX_W(28)) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .icache_cmd_valid         (icache_cmd_valid),
    .icache_cmd_ready         (icache_cmd_ready),
    .icache_cmd_payload_addr  (icache_cmd_payload_addr),
    .icache_rsp_valid         (icache_rsp_valid),
    .icache_rsp_payload_data  (icache_rsp_payload_data),
    .dcache_cmd_valid         (dcache_cmd_valid),
    .dcache_cmd_ready         (dcache_cmd_ready),
    .dcache_cmd_payload_addr  (dcache_cmd_payload_addr),
    .dcache_cmd_payload_wen   (dcache_cmd_payload_wen),
    .dcache_cmd_payload_wdata (dcache_cmd_payload_wdata),
    .dcache_cmd_payload_wstrb (dcache_cmd_payload_wstrb),
    .dcache_cmd_payload_size  (dcache_cmd_payload_size),
    .dcache_rsp_valid         (dcache_rsp_valid),
    .dcache_rsp_payload_data  (dcache_rsp_payload_data),
    .mem_en                   (mem_en),
    .mem_idx                  (mem_idx),
    .mem_rdata                (mem_rdata),
    .mem_wdata                (mem_wdata),
    .mem_wmask                (mem_wmask),
    .mem_wen                  (mem_wen)
  );

  always #5 clock = ~clock;

  // RAMHelper stand-in: combinational read, masked write at the edge.
  logic [63:0] tb_mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [63:0] pl_data = '0;
  assign mem_rdata = tb_mem[mem_idx[7:0]];
  always @(posedge clock) begin
    if (pl_en) tb_mem[pl_idx] <= pl_data;
    else if (mem_en && mem_wen)
      tb_mem[mem_idx[7:0]] <= (tb_mem[mem_idx[7:0]] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  // Reference model state
  logic [63:0] m_mem [256];
  bit          m_last = 1'b1;
  bit          e_iv, e_dv;
  logic [31:0] e_id = '0;
  logic [63:0] e_dd = '0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [7:0] widx(input logic [63:0] a);
    logic [63:0] o;
    o = (a - BASE) / 8;
    return o[7:0];
  endfunction

  function automatic logic [27:0] full_idx(input logic [63:0] a);
    logic [63:0] o;
    o = (a - BASE) / 8;
    return o[27:0];
  endfunction

  // 0 = nobody, 1 = fetch side, 2 = data side
  function automatic int who(input bit vi, input bit vd);
    if (!vi && !vd) return 0;
    if (vi && !vd) return 1;
    if (!vi && vd) return 2;
    if (!RR) return 2;
    return m_last ? 1 : 2;
  endfunction

  task automatic apply_edge(output int w);
    logic [63:0] word;
    logic [63:0] off;
    w = who(icache_cmd_valid, dcache_cmd_valid);
    e_iv = 1'b0;
    e_dv = 1'b0;
    if (w == 1) begin
      word = m_mem[widx(icache_cmd_payload_addr)];
      off  = icache_cmd_payload_addr - BASE;
      e_id = ((off / 4) % 2 == 1) ? word[63:32] : word[31:0];
      e_iv = 1'b1;
      m_last = 1'b0;
    end else if (w == 2) begin
      word = m_mem[widx(dcache_cmd_payload_addr)];
      m_last = 1'b1;
      if (dcache_cmd_payload_wen) begin
        for (int b = 0; b < 8; b++)
          if (dcache_cmd_payload_wstrb[b]) word[8*b +: 8] = dcache_cmd_payload_wdata[8*b +: 8];
        m_mem[widx(dcache_cmd_payload_addr)] = word;
      end else begin
        e_dv = 1'b1;
        e_dd = word;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    icache_cmd_valid = 1'b0;
    dcache_cmd_valid = 1'b0;
    dcache_cmd_payload_wen = 1'b0;
  endtask

  task automatic test_reset();
    pl_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pl_idx  = i[7:0];
      pl_data = (i == 0) ? 64'h1111_2222_3333_4444 : {$urandom, $urandom};
      m_mem[i] = pl_data;
      @(posedge clock);
      #1;
    end
    pl_en = 1'b0;
    icache_cmd_valid = 1'b1;
    dcache_cmd_valid = 1'b1;
    #2;
    checks++; if ({icache_cmd_ready, dcache_cmd_ready, mem_en, mem_wen} !== 4'b0) begin
      errors++; $display("FAIL reset_cmd_outputs got %b want 0000", {icache_cmd_ready, dcache_cmd_ready, mem_en, mem_wen}); end
    checks++; if ({icache_rsp_valid, dcache_rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_rsp_valid got %b want 00", {icache_rsp_valid, dcache_rsp_valid}); end
    checks++; if (icache_rsp_payload_data !== 32'd0 || dcache_rsp_payload_data !== 64'd0) begin
      errors++; $display("FAIL reset_rsp_data got %h/%h want 0/0", icache_rsp_payload_data, dcache_rsp_payload_data); end
    set_idle();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    m_last = 1'b1;
  endtask

  task automatic test_fetch();
    int w;
    icache_cmd_valid = 1'b1;
    icache_cmd_payload_addr = 64'h8000_0004;
    #2;
    checks++; if ({icache_cmd_ready, dcache_cmd_ready, mem_en, mem_wen} !== 4'b1010) begin
      errors++; $display("FAIL fetch_ready got %b want 1010", {icache_cmd_ready, dcache_cmd_ready, mem_en, mem_wen}); end
    checks++; if (mem_idx !== 28'd0) begin
      errors++; $display("FAIL fetch_idx got %h want 0", mem_idx); end
    apply_edge(w);
    icache_cmd_valid = 1'b0;
    checks++; if (icache_rsp_valid !== 1'b1 || icache_rsp_payload_data !== 32'h1111_2222) begin
      errors++; $display("FAIL fetch_rsp got %b/%h want 1/11112222", icache_rsp_valid, icache_rsp_payload_data); end
    apply_edge(w);
    checks++; if (icache_rsp_valid !== 1'b0 || icache_rsp_payload_data !== 32'h1111_2222) begin
      errors++; $display("FAIL fetch_pulse_hold got %b/%h want 0/11112222", icache_rsp_valid, icache_rsp_payload_data); end
  endtask

  task automatic test_write_read();
    int w;
    dcache_cmd_valid = 1'b1;
    dcache_cmd_payload_wen = 1'b1;
    dcache_cmd_payload_addr = 64'h8000_0010;
    dcache_cmd_payload_wstrb = 8'h0F;
    dcache_cmd_payload_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    #2;
    checks++; if (mem_wmask !== 64'h0000_0000_FFFF_FFFF || mem_wen !== 1'b1 || mem_idx !== 28'd2) begin
      errors++; $display("FAIL write_cmd got mask %h wen %b idx %h want 00000000ffffffff 1 2", mem_wmask, mem_wen, mem_idx); end
    checks++; if (mem_wdata !== 64'hAAAA_BBBB_CCCC_DDDD) begin
      errors++; $display("FAIL write_data got %h want aaaabbbbccccdddd", mem_wdata); end
    apply_edge(w);
    dcache_cmd_payload_wen = 1'b0;
    checks++; if (dcache_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL write_no_rsp got %b want 0", dcache_rsp_valid); end
    apply_edge(w);
    set_idle();
    checks++; if (dcache_rsp_valid !== 1'b1 || dcache_rsp_payload_data[31:0] !== 32'hCCCC_DDDD) begin
      errors++; $display("FAIL raw_rsp got %b/%h want 1/ccccdddd", dcache_rsp_valid, dcache_rsp_payload_data[31:0]); end
    checks++; if (dcache_rsp_payload_data !== e_dd) begin
      errors++; $display("FAIL raw_word got %h want %h", dcache_rsp_payload_data, e_dd); end
  endtask

  task automatic test_contention();
    int w, exp_w;
    icache_cmd_valid = 1'b1;
    icache_cmd_payload_addr = BASE + 64'd40;
    dcache_cmd_valid = 1'b1;
    dcache_cmd_payload_addr = BASE + 64'd72;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) set_idle();
      #2;
      exp_w = who(icache_cmd_valid, dcache_cmd_valid);
      checks++; if (icache_cmd_ready !== (exp_w == 1) || dcache_cmd_ready !== (exp_w == 2)) begin
        errors++; $display("FAIL contend_grant[%0d] got i%b d%b want i%b d%b", k, icache_cmd_ready, dcache_cmd_ready, exp_w == 1, exp_w == 2); end
      apply_edge(w);
      checks++; if (icache_rsp_valid !== e_iv || dcache_rsp_valid !== e_dv || icache_rsp_payload_data !== e_id || dcache_rsp_payload_data !== e_dd) begin
        errors++; $display("FAIL contend_rsp[%0d] got %b%b %h %h want %b%b %h %h", k, icache_rsp_valid, dcache_rsp_valid,
                           icache_rsp_payload_data, dcache_rsp_payload_data, e_iv, e_dv, e_id, e_dd); end
    end
  endtask

  task automatic test_stall();
    int w;
    bit done;
    done = 1'b0;
    icache_cmd_valid = 1'b1;
    icache_cmd_payload_addr = 64'h8000_0100;
    dcache_cmd_payload_addr = BASE + {$urandom_range(0, 255), 3'b000};
    for (int k = 0; k < 10 && !done; k++) begin
      dcache_cmd_valid = (k < 3);
      #2;
      if (icache_cmd_ready === 1'b1) begin
        checks++; if (mem_idx !== 28'h20) begin
          errors++; $display("FAIL stall_idx got %h want 20", mem_idx); end
      end
      apply_edge(w);
      if (w == 1) begin
        icache_cmd_valid = 1'b0;
        done = 1'b1;
      end
      if (w == 2) dcache_cmd_payload_addr = BASE + {$urandom_range(0, 255), 3'b000};
      checks++; if (icache_rsp_valid !== e_iv || icache_rsp_payload_data !== e_id || dcache_rsp_valid !== e_dv || dcache_rsp_payload_data !== e_dd) begin
        errors++; $display("FAIL stall_rsp[%0d] got %b%b %h %h want %b%b %h %h", k, icache_rsp_valid, dcache_rsp_valid,
                           icache_rsp_payload_data, dcache_rsp_payload_data, e_iv, e_dv, e_id, e_dd); end
    end
    set_idle();
    checks++; if (!done) begin
      errors++; $display("FAIL stall_timeout got no accept want accept within 10 cycles"); end
  endtask

  task automatic test_wrap();
    int w;
    dcache_cmd_valid = 1'b1;
    dcache_cmd_payload_addr = 64'h7FFF_FFF8;
    #2;
    checks++; if (mem_idx !== 28'hFFF_FFFF || mem_idx !== full_idx(dcache_cmd_payload_addr)) begin
      errors++; $display("FAIL wrap_idx got %h want fffffff", mem_idx); end
    apply_edge(w);
    set_idle();
    checks++; if (dcache_rsp_valid !== 1'b1 || dcache_rsp_payload_data !== e_dd) begin
      errors++; $display("FAIL wrap_rsp got %b/%h want 1/%h", dcache_rsp_valid, dcache_rsp_payload_data, e_dd); end
  endtask

  task automatic test_random();
    int w, exp_w;
    for (int n = 0; n < 300; n++) begin
      if (!icache_cmd_valid) begin
        icache_cmd_valid = $urandom_range(0, 1);
        icache_cmd_payload_addr = BASE + {$urandom_range(0, 15), 3'b000} + 64'(4 * $urandom_range(0, 1));
      end
      if (!dcache_cmd_valid) begin
        dcache_cmd_valid = $urandom_range(0, 1);
        dcache_cmd_payload_addr = BASE + {$urandom_range(0, 15), 3'b000};
        dcache_cmd_payload_wen = $urandom_range(0, 1);
        dcache_cmd_payload_wdata = {$urandom, $urandom};
        dcache_cmd_payload_wstrb = 8'($urandom);
      end
      #2;
      exp_w = who(icache_cmd_valid, dcache_cmd_valid);
      checks++; if (icache_cmd_ready !== (exp_w == 1) || dcache_cmd_ready !== (exp_w == 2) || mem_en !== (exp_w != 0)) begin
        errors++; $display("FAIL rand_grant[%0d] got i%b d%b en%b want grant %0d", n, icache_cmd_ready, dcache_cmd_ready, mem_en, exp_w); end
      if (exp_w != 0) begin
        checks++; if (mem_idx !== full_idx(exp_w == 1 ? icache_cmd_payload_addr : dcache_cmd_payload_addr)) begin
          errors++; $display("FAIL rand_idx[%0d] got %h", n, mem_idx); end
      end
      apply_edge(w);
      if (w == 1) icache_cmd_valid = 1'b0;
      if (w == 2) dcache_cmd_valid = 1'b0;
      checks++; if (icache_rsp_valid !== e_iv || icache_rsp_payload_data !== e_id || dcache_rsp_valid !== e_dv || dcache_rsp_payload_data !== e_dd) begin
        errors++; $display("FAIL rand_rsp[%0d] got %b%b %h %h want %b%b %h %h", n, icache_rsp_valid, dcache_rsp_valid,
                           icache_rsp_payload_data, dcache_rsp_payload_data, e_iv, e_dv, e_id, e_dd); end
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    int w, exp_w;
    dcache_cmd_valid = 1'b1;
    dcache_cmd_payload_wen = 1'b0;
    dcache_cmd_payload_addr = BASE + 64'h40;
    apply_edge(w);
    reset_n = 1'b0;
    #1;
    checks++; if (dcache_rsp_valid !== 1'b0 || dcache_rsp_payload_data !== 64'd0) begin
      errors++; $display("FAIL midreset_rsp got %b/%h want 0/0", dcache_rsp_valid, dcache_rsp_payload_data); end
    checks++; if (dcache_cmd_ready !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL midreset_cmd got ready %b en %b want 0 0", dcache_cmd_ready, mem_en); end
    @(posedge clock);
    #1;
    set_idle();
    reset_n = 1'b1;
    m_last = 1'b1;
    e_iv = 1'b0; e_dv = 1'b0; e_id = '0; e_dd = '0;
    for (int k = 0; k < 3; k++) begin
      apply_edge(w);
      checks++; if (dcache_rsp_valid !== 1'b0 || icache_rsp_valid !== 1'b0) begin
        errors++; $display("FAIL midreset_pulse[%0d] got %b%b want 00", k, icache_rsp_valid, dcache_rsp_valid); end
    end
    icache_cmd_valid = 1'b1;
    dcache_cmd_valid = 1'b1;
    icache_cmd_payload_addr = BASE;
    #2;
    exp_w = who(1'b1, 1'b1);
    checks++; if (icache_cmd_ready !== (exp_w == 1) || dcache_cmd_ready !== (exp_w == 2)) begin
      errors++; $display("FAIL first_contend got i%b d%b want grant %0d", icache_cmd_ready, dcache_cmd_ready, exp_w); end
    apply_edge(w);
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_contention();
    test_stall();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port simulation memory (RAMHelper-style: combinational read by index, write on clock edge) between the core's instruction-fetch and data command/response interfaces. Sits in the simulation top between the core and a single RAMHelper instance, replacing the two-instance arrangement. Arbitrates one command per cycle, translates byte addresses to 64-bit word indices, and returns registered responses one cycle after acceptance.

## Interface
- BASE_ADDR, 64'h8000_0000, physical address mapped to memory index 0
- IDX_W, 28, memory word-index width
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- icache_cmd_valid  in  1  fetch request
- icache_cmd_ready  out  1  fetch request accepted this cycle
- icache_cmd_payload_addr  in  64  fetch byte address, 4-byte aligned
- icache_rsp_valid  out  1  fetch data valid, one-cycle pulse
- icache_rsp_payload_data  out  32  instruction word
- dcache_cmd_valid  in  1  data request
- dcache_cmd_ready  out  1  data request accepted this cycle
- dcache_cmd_payload_addr  in  64  data byte address
- dcache_cmd_payload_wen  in  1  1 = write, 0 = read
- dcache_cmd_payload_wdata  in  64  write data, lane-aligned
- dcache_cmd_payload_wstrb  in  8  byte enables
- dcache_cmd_payload_size  in  3  access size; passed through, not interpreted
- dcache_rsp_valid  out  1  read data valid, one-cycle pulse; writes never respond
- dcache_rsp_payload_data  out  64  full 64-bit word read
- mem_en  out  1  memory access this cycle
- mem_idx  out  IDX_W  word index, used for both read and write
- mem_rdata  in  64  combinational read data for mem_idx
- mem_wdata  out  64  write data
- mem_wmask  out  64  bit mask, each wstrb bit expanded to 8 bits
- mem_wen  out  1  write enable

## Operation
- Each cycle, at most one command is granted. Grant is combinational from the valid signals and the last_grant register. Ready is asserted only to the granted requester.
- If only one requester is valid, it is granted.
- If both are valid, the policy is set by the configuration macro.
- On grant:
  - mem_en=1.
  - mem_idx = (addr − BASE_ADDR)[IDX_W+2:3]. The subtraction wraps modulo 2^64 and there is no range check.
  - mem_wen = dcache_cmd_payload_wen & dcache granted.
  - mem_wdata and mem_wmask are driven from the dcache payload. They are 0 when icache is granted.
- Accepted icache read: on the next edge, icache_rsp_payload_data ← mem_rdata[32*a2 +: 32], where a2 = (addr − BASE_ADDR)[2], and icache_rsp_valid ← 1.
- Accepted dcache read: on the next edge, dcache_rsp_payload_data ← mem_rdata and dcache_rsp_valid ← 1.
- Accepted dcache write: the memory write commits at the edge and no response is produced.
- Response valids are single-cycle pulses. Requesters have no response backpressure and must sink them.
- A requester whose valid is not accepted must hold valid and payload stable. The arbiter does not latch unaccepted commands.
- Response data registers hold their last value when valid is low.
- last_grant register: 0 = icache, 1 = dcache. It updates on every grant.

## Timing
- Command-to-response latency: 1 cycle.
- Throughput: 1 accepted command per cycle. Back-to-back accepts from the same or alternating requesters are allowed. A response for cycle N and an accept in cycle N+1 overlap without conflict.
- Reset values: icache_rsp_valid=0, dcache_rsp_valid=0, both rsp_payload_data=0, last_grant=1 (so icache wins the first contention in round-robin mode).
- Reset asserted mid-operation clears pending response valids asynchronously; the in-flight response is dropped. Writes already committed to memory stay committed.
- Outputs mem_*, cmd_ready are combinational and forced 0 while reset_n=0.
- Read-after-write to the same index on consecutive cycles returns the new data, because the write commits at the edge before the next combinational read.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on contention, grant goes to the requester that did not win the last grant. This gives strict alternation under continuous contention.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority with dcache always winning contention, since fetch can wait. last_grant is still maintained but does not affect the grant.

## Structure
- Shared package mem_arb_pkg holds:
  - BASE_ADDR default
  - grant encoding constants GNT_ICACHE=1'b0, GNT_DCACHE=1'b1
  - a wstrb-to-bit-mask expansion function
- One natural sub-module: mem_arb_grant, the combinational grant logic from both valids and last_grant. The round-robin macro is applied only there.

## Test plan
- Single icache fetch at 0x8000_0004, memory word 0 = 0x1111_2222_3333_4444 -> ready same cycle, mem_idx=0; next cycle icache_rsp_valid=1, data=0x1111_2222.
- dcache write to 0x8000_0010, wstrb=0x0F, wdata=0xAAAA_BBBB_CCCC_DDDD, then read the same address next cycle -> mem_wmask=0x0000_0000_FFFF_FFFF, no response for the write; read response has low word 0xCCCC_DDDD.
- Both valid continuously for 4 cycles, round-robin enabled -> grants I, D, I, D and responses alternate one cycle later. With the macro undefined -> D, D, D, D and the icache ready stays 0.
- Contention loser holds addr 0x8000_0100 while stalled -> it is accepted the next free cycle with mem_idx=0x20 and a correct response.
- reset_n dropped in the cycle after a dcache read is accepted -> dcache_rsp_valid reads 0 immediately and no pulse appears after reset release.
- Address 0x7FFF_FFF8, below BASE_ADDR -> mem_idx wraps to all ones (0xFFF_FFFF) with no error.
